nv_nvdla_bdma_grp_sched: RTL and testbench
==========================================

Name: nv_nvdla_bdma_grp_sched

Overview:
- Two-group command scheduler between the BDMA CSB register block and the load engine.
- Accepts per-group launch pulses and issues them to the load engine in launch order.
- Bounds the number of in-flight operations and retires them in order on store-done pulses.
- Produces per-group done interrupts, busy/idle status, a sticky protocol-error flag and an issue-stall counter.

Parameters:
- MAX_INFLIGHT, 2, max operations issued to load but not yet done; legal values 1 or 2.
- STALL_W, 32, stall counter width.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset, synchronous, active-low
- csb2sched_launch_vld  in  1  launch request
- csb2sched_launch_rdy  out  1  launch accepted when vld&rdy
- csb2sched_launch_grp  in  1  group id of launch
- csb2sched_launch_irq  in  1  raise interrupt on completion of this launch
- csb2sched_en  in  1  issue enable; 0 = hold pending ops, no new issue
- sched2ld_vld  out  1  issue valid to load engine
- sched2ld_rdy  in  1  load engine accepts issue
- sched2ld_grp  out  1  group id being issued
- sched2ld_irq  out  1  irq flag of issued op
- st2sched_done  in  1  one-cycle pulse: oldest in-flight op completed
- sched2glb_done_intr_pd  out  2  one-cycle per-group done interrupt pulse
- sched2csb_grp_busy  out  2  group g launched and not yet done
- sched2csb_idle  out  1  nothing pending, nothing in flight
- sched2csb_err  out  1  sticky: done received with no op in flight
- csb2sched_err_clr  in  1  clears err
- sched2csb_stall_cnt  out  STALL_W  cycles sched2ld_vld=1 and sched2ld_rdy=0
- csb2sched_stall_clr  in  1  clears stall counter

Behaviour:
- Reset values (nvdla_core_rstn=0 sampled at clk edge):
  - all state cleared; sched2ld_vld=0, grp/irq=0, intr_pd=0, grp_busy=0, idle=1, err=0, stall_cnt=0.
  - Reset mid-operation discards all pending and in-flight ops; no interrupt is generated.
- Launch acceptance:
  - launch_rdy = !grp_busy[launch_grp] (combinational on registered busy).
  - On accept: busy[grp] set next cycle; {grp,irq} pushed to 2-entry pending FIFO.
  - Pending FIFO cannot overflow: at most one op per group exists.
- Issue FSM, three states:
  - IDLE: go to REQ when pending nonempty, csb2sched_en=1 and inflight_cnt<MAX_INFLIGHT.
  - REQ: sched2ld_vld=1 with head grp/irq registered and stable until accepted. On vld&rdy: pop pending, inflight push, return to IDLE. Deassertion of csb2sched_en while in REQ does not drop vld (no valid retraction).
  - Earliest issue is the cycle after launch accept (1-cycle latency). Back-to-back issues are separated by at least one IDLE cycle.
  - HOLD: not used when MAX_INFLIGHT=2. When MAX_INFLIGHT=1, entered instead of IDLE after an issue; stays until the done for that op, then goes to IDLE.
- In-flight FIFO: 2 entries of {grp,irq}; inflight_cnt 0..2.
- Retirement on st2sched_done=1 with inflight_cnt>0:
  - pop head; busy[grp] cleared next cycle.
  - if irq=1: sched2glb_done_intr_pd[grp]=1 for exactly one cycle, the cycle after done.
- st2sched_done with inflight_cnt=0: ignored, err set next cycle.
- err_clr and a new error in the same cycle: error wins, err stays 1.
- Simultaneous events:
  - issue-accept and done in the same cycle: inflight_cnt unchanged; push and pop both occur.
  - launch for a group in the same cycle its done arrives: rejected (busy still 1); accepted the following cycle.
  - launch of the other group in the same cycle as done: accepted normally.
- sched2csb_idle = pending empty & inflight_cnt==0 & FSM in IDLE (registered view).

Optional Feature:
- Macro NVDLA_BDMA_SCHED_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle sched2ld_vld&!sched2ld_rdy and saturates at all-ones. csb2sched_stall_clr zeroes it next cycle; clr has priority over increment.
- Undefined: counter logic absent, sched2csb_stall_cnt tied to 0, csb2sched_stall_clr unused.

Test Plan:
- Launch grp0 irq=1, load rdy=1, done 5 cycles later -> vld one cycle after launch with grp=0; intr_pd=2'b01 one cycle after done; busy 01->00; idle=1.
- Launch grp1 then grp0 on consecutive cycles, irq=1 both, en=1 -> issue order grp1 then grp0; two dones -> intr 2'b10 then 2'b01.
- MAX_INFLIGHT=1, both groups launched -> second vld only after first done; with MAX_INFLIGHT=2 second issues before any done.
- Relaunch grp0 while busy -> launch_rdy=0; in the done cycle still 0; next cycle 1 and accepted.
- Done with nothing in flight -> err=1, stays set; err_clr -> 0 next cycle; irq=0 launch completes with intr_pd=0.
- Macro defined, load rdy=0 for 10 cycles during REQ -> stall_cnt=10, grp/irq stable throughout; stall_clr -> 0; preset near max -> saturates at 2^STALL_W-1. Reset asserted during REQ -> vld=0, busy=0, no intr.

Source files
------------

// File: rtl/nv_nvdla_bdma_grp_sched.sv
// Two-group BDMA command scheduler: in-order issue to load, bounded in-flight, in-order retire.
// Optional stall counter enabled by NVDLA_BDMA_SCHED_STALL_CNT_EN.
module nv_nvdla_bdma_grp_sched #(
  parameter int MAX_INFLIGHT = 2,
  parameter int STALL_W      = 32
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic               csb2sched_launch_vld,
  output logic               csb2sched_launch_rdy,
  input  logic               csb2sched_launch_grp,
  input  logic               csb2sched_launch_irq,
  input  logic               csb2sched_en,
  output logic               sched2ld_vld,
  input  logic               sched2ld_rdy,
  output logic               sched2ld_grp,
  output logic               sched2ld_irq,
  input  logic               st2sched_done,
  output logic [1:0]         sched2glb_done_intr_pd,
  output logic [1:0]         sched2csb_grp_busy,
  output logic               sched2csb_idle,
  output logic               sched2csb_err,
  input  logic               csb2sched_err_clr,
  output logic [STALL_W-1:0] sched2csb_stall_cnt,
  input  logic               csb2sched_stall_clr
);

  localparam logic [1:0] MAX_C = 2'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t          state, state_nxt;
  logic [1:0]      busy;
  logic [1:0][1:0] pend_q;
  logic            pend_rd, pend_wr;
  logic [1:0]      pend_cnt;
  logic [1:0][1:0] infl_q;
  logic            infl_rd, infl_wr;
  logic [1:0]      infl_cnt;
  logic            ld_grp, ld_irq;
  logic [1:0]      intr_pd;
  logic            err;

  logic            launch_acc, issue_acc, done_ok, done_bad, have_op, load_head;
  logic [1:0]      head_op, ret_op, busy_set, busy_clr;

  assign csb2sched_launch_rdy = !busy[csb2sched_launch_grp];
  assign launch_acc = csb2sched_launch_vld && !busy[csb2sched_launch_grp];
  assign issue_acc  = (state == S_REQ) && sched2ld_rdy;
  assign done_ok    = st2sched_done && (infl_cnt != 2'd0);
  assign done_bad   = st2sched_done && (infl_cnt == 2'd0);
  assign ret_op     = infl_q[infl_rd];

  // A launch accepted this cycle is visible to the issue logic immediately,
  // giving one cycle from accept to sched2ld_vld.
  assign have_op = (pend_cnt != 2'd0) || launch_acc;
  assign head_op = (pend_cnt != 2'd0) ? pend_q[pend_rd]
                                      : {csb2sched_launch_grp, csb2sched_launch_irq};

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    case (state)
      S_IDLE: begin
        if (have_op && csb2sched_en && (infl_cnt < MAX_C)) begin
          state_nxt = S_REQ;
          load_head = 1'b1;
        end
      end
      S_REQ: begin
        if (sched2ld_rdy) state_nxt = (MAX_INFLIGHT == 1) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (done_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_set = 2'b00;
    busy_clr = 2'b00;
    if (launch_acc) busy_set[csb2sched_launch_grp] = 1'b1;
    if (done_ok)    busy_clr[ret_op[1]] = 1'b1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state    <= S_IDLE;
      busy     <= 2'b00;
      pend_q   <= '0;
      pend_rd  <= 1'b0;
      pend_wr  <= 1'b0;
      pend_cnt <= 2'd0;
      infl_q   <= '0;
      infl_rd  <= 1'b0;
      infl_wr  <= 1'b0;
      infl_cnt <= 2'd0;
      ld_grp   <= 1'b0;
      ld_irq   <= 1'b0;
      intr_pd  <= 2'b00;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (busy | busy_set) & ~busy_clr;

      if (launch_acc) begin
        pend_q[pend_wr] <= {csb2sched_launch_grp, csb2sched_launch_irq};
        pend_wr         <= ~pend_wr;
      end
      if (issue_acc) pend_rd <= ~pend_rd;
      pend_cnt <= pend_cnt + {1'b0, launch_acc} - {1'b0, issue_acc};

      if (issue_acc) begin
        infl_q[infl_wr] <= {ld_grp, ld_irq};
        infl_wr         <= ~infl_wr;
      end
      if (done_ok) infl_rd <= ~infl_rd;
      infl_cnt <= infl_cnt + {1'b0, issue_acc} - {1'b0, done_ok};

      if (load_head) {ld_grp, ld_irq} <= head_op;

      intr_pd <= 2'b00;
      if (done_ok && ret_op[0]) intr_pd[ret_op[1]] <= 1'b1;

      if (done_bad)               err <= 1'b1;
      else if (csb2sched_err_clr) err <= 1'b0;
    end
  end

  assign sched2ld_vld           = (state == S_REQ);
  assign sched2ld_grp           = ld_grp;
  assign sched2ld_irq           = ld_irq;
  assign sched2glb_done_intr_pd = intr_pd;
  assign sched2csb_grp_busy     = busy;
  assign sched2csb_err          = err;
  assign sched2csb_idle         = (pend_cnt == 2'd0) && (infl_cnt == 2'd0) && (state == S_IDLE);

`ifdef NVDLA_BDMA_SCHED_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn)                                     stall_cnt <= '0;
    else if (csb2sched_stall_clr)                             stall_cnt <= '0;
    else if (sched2ld_vld && !sched2ld_rdy && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign sched2csb_stall_cnt = stall_cnt;
`else
  logic stall_clr_unused;
  assign stall_clr_unused    = csb2sched_stall_clr;
  assign sched2csb_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_bdma_grp_sched.sv
// Bench for nv_nvdla_bdma_grp_sched: directed table, corner sequences, random vs queue model.
module tb_nv_nvdla_bdma_grp_sched;

`ifdef NVDLA_BDMA_SCHED_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, l_vld, l_grp, l_irq, en, ld_rdy, done, err_clr, stall_clr;
  logic [1:0] l_rdy, vld, lgrp, lirq, idle, err;
  logic [1:0] intr [2];
  logic [1:0] busy [2];
  logic [31:0] stall0;
  logic [3:0]  stall1;

  nv_nvdla_bdma_grp_sched #(.MAX_INFLIGHT(2), .STALL_W(32)) u_dut0 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .csb2sched_launch_vld(l_vld), .csb2sched_launch_rdy(l_rdy[0]),
    .csb2sched_launch_grp(l_grp), .csb2sched_launch_irq(l_irq),
    .csb2sched_en(en), .sched2ld_vld(vld[0]), .sched2ld_rdy(ld_rdy),
    .sched2ld_grp(lgrp[0]), .sched2ld_irq(lirq[0]), .st2sched_done(done),
    .sched2glb_done_intr_pd(intr[0]), .sched2csb_grp_busy(busy[0]),
    .sched2csb_idle(idle[0]), .sched2csb_err(err[0]), .csb2sched_err_clr(err_clr),
    .sched2csb_stall_cnt(stall0), .csb2sched_stall_clr(stall_clr));

  nv_nvdla_bdma_grp_sched #(.MAX_INFLIGHT(1), .STALL_W(4)) u_dut1 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .csb2sched_launch_vld(l_vld), .csb2sched_launch_rdy(l_rdy[1]),
    .csb2sched_launch_grp(l_grp), .csb2sched_launch_irq(l_irq),
    .csb2sched_en(en), .sched2ld_vld(vld[1]), .sched2ld_rdy(ld_rdy),
    .sched2ld_grp(lgrp[1]), .sched2ld_irq(lirq[1]), .st2sched_done(done),
    .sched2glb_done_intr_pd(intr[1]), .sched2csb_grp_busy(busy[1]),
    .sched2csb_idle(idle[1]), .sched2csb_err(err[1]), .csb2sched_err_clr(err_clr),
    .sched2csb_stall_cnt(stall1), .csb2sched_stall_clr(stall_clr));

  int nvec = 0;
  int nfail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: ops are {grp,irq}; pending and in-flight are ordered lists.
  typedef bit [1:0] op_t;
  op_t    pq [2][2];
  op_t    iq [2][2];
  int     pn [2];
  int     inn [2];
  bit [1:0] mbusy [2];
  bit [1:0] mintr [2];
  bit     mvld [2];
  op_t    mhead [2];
  bit     merr [2];
  longint mstall [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      pn[m] = 0; inn[m] = 0; mbusy[m] = 0; mintr[m] = 0;
      mvld[m] = 0; mhead[m] = 0; merr[m] = 0; mstall[m] = 0;
    end
  endtask

  task automatic model_step();
    bit acc, iss, dok, bad, start;
    bit [1:0] setb, clrb;
    op_t hd, r;
    int maxv;
    longint smax;
    for (int m = 0; m < 2; m++) begin
      maxv  = (m == 0) ? 2 : 1;
      smax  = (m == 0) ? 64'hFFFF_FFFF : 64'd15;
      acc   = l_vld && !mbusy[m][l_grp];
      iss   = mvld[m] && ld_rdy;
      dok   = done && (inn[m] > 0);
      bad   = done && (inn[m] == 0);
      start = !mvld[m] && ((pn[m] > 0) || acc) && en && (inn[m] < maxv);
      hd    = (pn[m] > 0) ? pq[m][0] : {l_grp, l_irq};
      if (STALL_EN) begin
        if (stall_clr) mstall[m] = 0;
        else if (mvld[m] && !ld_rdy && mstall[m] < smax) mstall[m]++;
      end
      mintr[m] = 0; setb = 0; clrb = 0;
      if (dok) begin
        r = iq[m][0]; iq[m][0] = iq[m][1]; inn[m]--;
        clrb[r[1]] = 1'b1;
        if (r[0]) mintr[m][r[1]] = 1'b1;
      end
      if (iss) begin
        iq[m][inn[m]] = pq[m][0]; inn[m]++;
        pq[m][0] = pq[m][1]; pn[m]--;
        mvld[m] = 0;
      end
      if (acc) begin
        pq[m][pn[m]] = {l_grp, l_irq}; pn[m]++;
        setb[l_grp] = 1'b1;
      end
      if (start) begin mvld[m] = 1; mhead[m] = hd; end
      mbusy[m] = (mbusy[m] | setb) & ~clrb;
      if (bad) merr[m] = 1;
      else if (err_clr) merr[m] = 0;
    end
  endtask

  task automatic tick();
    if (!rstn) model_reset();
    else       model_step();
    @(posedge clk); #1;
  endtask

  task automatic check_model(string tag);
    logic [31:0] sa;
    for (int m = 0; m < 2; m++) begin
      sa = (m == 0) ? stall0 : {28'd0, stall1};
      chk($sformatf("%s_vld%0d", tag, m), 32'(vld[m]), 32'(mvld[m]));
      if (mvld[m]) chk($sformatf("%s_head%0d", tag, m), 32'({lgrp[m], lirq[m]}), 32'(mhead[m]));
      chk($sformatf("%s_busy%0d", tag, m), 32'(busy[m]), 32'(mbusy[m]));
      chk($sformatf("%s_intr%0d", tag, m), 32'(intr[m]), 32'(mintr[m]));
      chk($sformatf("%s_idle%0d", tag, m), 32'(idle[m]),
          32'((pn[m] == 0) && (inn[m] == 0) && !mvld[m]));
      chk($sformatf("%s_err%0d", tag, m), 32'(err[m]), 32'(merr[m]));
      chk($sformatf("%s_stall%0d", tag, m), sa, mstall[m][31:0]);
    end
  endtask

  task automatic quiet();
    l_vld = 0; l_grp = 0; l_irq = 0; en = 1; ld_rdy = 1;
    done = 0; err_clr = 0; stall_clr = 0;
  endtask

  task automatic do_reset();
    quiet(); rstn = 0; tick(); tick(); rstn = 1;
  endtask

  task automatic launch(bit g, bit i);
    l_vld = 1; l_grp = g; l_irq = i;
  endtask

  typedef struct {
    bit lv, lg, li, en, rdy, dn, ec;
    bit ev, eg;
    bit [1:0] eb, ei;
    bit eid, eer;
  } vec_t;
  vec_t tv [$];

  initial begin
    // inputs: lv lg li en rdy dn ec | expected (dut0): vld grp busy intr idle err
    tv.push_back('{1,0,1,1,1,0,0, 1,0,2'b01,2'b00,0,0});
    for (int k = 0; k < 5; k++) tv.push_back('{0,0,0,1,1,0,0, 0,0,2'b01,2'b00,0,0});
    tv.push_back('{0,0,0,1,1,1,0, 0,0,2'b00,2'b01,1,0});
    tv.push_back('{0,0,0,1,1,0,0, 0,0,2'b00,2'b00,1,0});
    tv.push_back('{1,1,1,1,1,0,0, 1,1,2'b10,2'b00,0,0});
    tv.push_back('{1,0,1,1,1,0,0, 0,0,2'b11,2'b00,0,0});
    tv.push_back('{0,0,0,1,1,0,0, 1,0,2'b11,2'b00,0,0});
    tv.push_back('{0,0,0,1,1,0,0, 0,0,2'b11,2'b00,0,0});
    tv.push_back('{0,0,0,1,1,1,0, 0,0,2'b01,2'b10,0,0});
    tv.push_back('{0,0,0,1,1,1,0, 0,0,2'b00,2'b01,1,0});
    tv.push_back('{0,0,0,1,1,1,0, 0,0,2'b00,2'b00,1,1});
    tv.push_back('{0,0,0,1,1,0,0, 0,0,2'b00,2'b00,1,1});
    tv.push_back('{0,0,0,1,1,0,1, 0,0,2'b00,2'b00,1,0});
    tv.push_back('{1,1,0,1,1,0,0, 1,1,2'b10,2'b00,0,0});
    tv.push_back('{0,0,0,1,1,0,0, 0,0,2'b10,2'b00,0,0});
    tv.push_back('{0,0,0,1,1,1,0, 0,0,2'b00,2'b00,1,0});
    tv.push_back('{1,0,1,0,1,0,0, 0,0,2'b01,2'b00,0,0});
    tv.push_back('{0,0,0,0,1,0,0, 0,0,2'b01,2'b00,0,0});
    tv.push_back('{0,0,0,1,0,0,0, 1,0,2'b01,2'b00,0,0});
    tv.push_back('{0,0,0,0,0,0,0, 1,0,2'b01,2'b00,0,0});
    tv.push_back('{0,0,0,0,1,0,0, 0,0,2'b01,2'b00,0,0});
    tv.push_back('{0,0,0,1,1,1,0, 0,0,2'b00,2'b01,1,0});

    rstn = 0;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      chk("rst_vld", 32'(vld[m]), 0);
      chk("rst_busy", 32'(busy[m]), 0);
      chk("rst_intr", 32'(intr[m]), 0);
      chk("rst_idle", 32'(idle[m]), 1);
      chk("rst_err", 32'(err[m]), 0);
    end
    chk("rst_stall0", stall0, 0);
    chk("rst_stall1", 32'(stall1), 0);

    foreach (tv[i]) begin
      l_vld = tv[i].lv; l_grp = tv[i].lg; l_irq = tv[i].li; en = tv[i].en;
      ld_rdy = tv[i].rdy; done = tv[i].dn; err_clr = tv[i].ec;
      tick();
      chk($sformatf("tv%0d_vld", i), 32'(vld[0]), 32'(tv[i].ev));
      if (tv[i].ev) chk($sformatf("tv%0d_grp", i), 32'(lgrp[0]), 32'(tv[i].eg));
      chk($sformatf("tv%0d_busy", i), 32'(busy[0]), 32'(tv[i].eb));
      chk($sformatf("tv%0d_intr", i), 32'(intr[0]), 32'(tv[i].ei));
      chk($sformatf("tv%0d_idle", i), 32'(idle[0]), 32'(tv[i].eid));
      chk($sformatf("tv%0d_err", i), 32'(err[0]), 32'(tv[i].eer));
    end

    // Relaunch while busy: rejected, still rejected in the done cycle, accepted after.
    do_reset();
    launch(0, 1); tick();
    quiet(); tick();
    launch(0, 1); #1;
    chk("relaunch_rdy_busy", 32'(l_rdy[0]), 0);
    tick();
    chk("relaunch_rejected_vld", 32'(vld[0]), 0);
    done = 1; #1;
    chk("relaunch_rdy_donecyc", 32'(l_rdy[0]), 0);
    tick();
    chk("relaunch_busy_after_done", 32'(busy[0]), 2'b00);
    chk("relaunch_intr", 32'(intr[0]), 2'b01);
    done = 0; launch(0, 0); #1;
    chk("relaunch_rdy_free", 32'(l_rdy[0]), 1);
    tick();
    chk("relaunch_busy_set", 32'(busy[0]), 2'b01);
    chk("relaunch_vld", 32'(vld[0]), 1);
    quiet(); tick();
    done = 1; tick();
    chk("relaunch_noirq_intr", 32'(intr[0]), 0);
    chk("relaunch_idle", 32'(idle[0]), 1);

    // MAX_INFLIGHT=1 holds the second issue until the first done; MAX_INFLIGHT=2 does not.
    do_reset();
    launch(0, 1); tick();
    chk("mi_first_vld1", 32'(vld[1]), 1);
    launch(1, 1); tick();
    quiet(); tick();
    chk("mi2_second_vld", 32'(vld[0]), 1);
    chk("mi2_second_grp", 32'(lgrp[0]), 1);
    chk("mi1_held_vld", 32'(vld[1]), 0);
    tick();
    chk("mi1_held_vld2", 32'(vld[1]), 0);
    done = 1; tick();
    chk("mi1_first_intr", 32'(intr[1]), 2'b01);
    chk("mi1_vld_doneedge", 32'(vld[1]), 0);
    done = 0; tick();
    chk("mi1_second_vld", 32'(vld[1]), 1);
    chk("mi1_second_grp", 32'(lgrp[1]), 1);
    tick();
    done = 1; tick();
    chk("mi1_second_intr", 32'(intr[1]), 2'b10);

    if (STALL_EN) begin
      do_reset();
      launch(0, 1); ld_rdy = 0; tick();
      quiet(); ld_rdy = 0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        chk("stall_vld", 32'(vld[0]), 1);
        chk("stall_head_stable", 32'({lgrp[0], lirq[0]}), 2'b01);
        if (k == 10) chk("stall_cnt10", stall0, 10);
      end
      chk("stall_cnt20", stall0, 20);
      chk("stall_sat", 32'(stall1), 15);
      stall_clr = 1; tick();
      chk("stall_clr0", stall0, 0);
      chk("stall_clr1", 32'(stall1), 0);
      quiet(); tick();
      done = 1; tick();
      check_model("stall_end");
    end

    // Reset while a request is outstanding drops everything with no interrupt.
    do_reset();
    launch(1, 1); ld_rdy = 0; tick();
    chk("rstreq_vld_pre", 32'(vld[0]), 1);
    quiet(); ld_rdy = 0; rstn = 0; tick();
    for (int m = 0; m < 2; m++) begin
      chk("rstreq_vld", 32'(vld[m]), 0);
      chk("rstreq_busy", 32'(busy[m]), 0);
      chk("rstreq_intr", 32'(intr[m]), 0);
      chk("rstreq_idle", 32'(idle[m]), 1);
    end
    rstn = 1; tick();
    chk("rstreq_intr_after", 32'(intr[0]), 0);
    chk("rstreq_vld_after", 32'(vld[0]), 0);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      l_vld     = ($urandom_range(0, 9) < 4);
      l_grp     = 1'($urandom);
      l_irq     = 1'($urandom);
      en        = ($urandom_range(0, 19) != 0);
      ld_rdy    = ($urandom_range(0, 9) < 7);
      done      = ($urandom_range(0, 9) < 3);
      err_clr   = ($urandom_range(0, 9) == 0);
      stall_clr = ($urandom_range(0, 29) == 0);
      #1;
      chk("rnd_lrdy0", 32'(l_rdy[0]), 32'(!mbusy[0][l_grp]));
      chk("rnd_lrdy1", 32'(l_rdy[1]), 32'(!mbusy[1][l_grp]));
      tick();
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
